scrambler_par: RTL and testbench
================================

Name: scrambler_par

Overview:
- Parametrised, multi-bit-per-cycle 802.11a scrambler/descrambler using the generator x^7 + x^4 + 1.
- Processes DATA_W bits per accepted beat over a valid/ready stream, with runtime mode select: scramble, descramble with SERVICE-field seed recovery, descramble with known seed, or bypass.
- Sits between the PPDU bit source and the convolutional encoder on TX, and between the Viterbi decoder and the MAC bit sink on RX.

Parameters:
- DATA_W, 8, bits per beat (1..16); bit 0 is first in time.
- SEED_DEFAULT, 7'h7F, LFSR state after reset.
- REC_BITS, 7, leading bits consumed for seed recovery in mode 1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches mode and seed, and re-arms recovery.
- mode  in  2  0 = scramble, 1 = descramble with recovery, 2 = descramble with seed, 3 = bypass; sampled only on start.
- seed  in  7  initial LFSR state, used on start in modes 0 and 2.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  input bits.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  processed bits.
- out_last  out  1  in_last delayed with its beat.
- lfsr_state  out  7  current LFSR state, for debug/pilot use.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid = 0, out_data = 0, out_last = 0.
  - lfsr_state = SEED_DEFAULT, mode register = 0, recovery counter = 0.
  - Any beat held in the output register is discarded.
- in_ready = !out_valid || out_ready; this is a single output register with no combinational path from in_valid to out_valid.
- Latency: exactly 1 cycle from acceptance to out_valid. Throughput: one beat per cycle while out_ready = 1.
- Output stall: out_data and out_last are held stable while out_valid && !out_ready.
- Per bit j = 0..DATA_W-1, processed sequentially within one beat (unrolled). With LFSR state s[7:1]: fb = s[7] ^ s[4].
  - Mode 0/2: out bit = d ^ fb; s <= {s[6:1], fb}.
  - Mode 1, while recovery counter < REC_BITS: out bit = 0; s <= {s[6:1], d}; counter increments per bit. Recovery may end mid-beat; remaining bits of that beat use the normal rule.
  - Mode 1, after recovery: same rule as modes 0/2.
  - Mode 3: out bit = d; LFSR unchanged.
- LFSR wrap: the period is 127; the all-zero state is never reached from a nonzero seed.
- start:
  - Loads the mode register.
  - Loads s <= seed in modes 0/2, or SEED_DEFAULT in modes 1/3.
  - Clears the recovery counter.
- start in the same cycle as an accepted beat: start applies first, and the beat uses the new configuration.
- start while the output is stalled: takes effect immediately; the held output beat is unaffected.
- seed = 0 in modes 0/2 is legal: the output equals the input (all-zero keystream).
- in_last does not modify state; a frame boundary requires start.
- Reset asserted mid-frame overrides start and in_valid in the same cycle.

Decomposition:
- Package scr_pkg:
  - POLY_TAP_A = 7, POLY_TAP_B = 4.
  - LFSR_W = 7.
  - Mode typedef/constants: MODE_SCR, MODE_DESCR_REC, MODE_DESCR_SEED, MODE_BYPASS.
  - SEED_DEFAULT.
- Sub-module scr_lfsr_unroll (combinational, DATA_W parameter):
  - Inputs: state, data, mode, recovery counter.
  - Outputs: next state, output bits, next counter.
- Top scrambler_par holds the registers and the handshake.

Test Plan:
- Mode 0, seed 7'h7F, DATA_W = 8, in_data = 0 for 2 beats -> out_data time-order bits 00001110 then 11110010; 127-beat-bit period check.
- Scramble with seed 7'h5D (arbitrary 128 bits), loop into a second instance in mode 1, with the first 7 plaintext bits zero -> descrambled output equals plaintext for all bits after bit 6, and bits 0..6 are output as 0.
- Mode 2 with the same seed 7'h5D on the scrambled stream -> exact plaintext match including bits 0..6; mode 3 -> out_data == in_data, and lfsr_state constant.
- Random out_ready backpressure (50%) with continuous in_valid -> no beat lost or duplicated, out_data stable during stall, out_last aligned, lfsr_state advances only on accepted beats.
- start asserted with an accepted beat and during a stall -> the beat uses the new seed; the stalled beat is unchanged.
- Reset asserted mid-frame with out_valid = 1 -> next cycle out_valid = 0, lfsr_state = 7'h7F, and in_ready = 1.

Source files
------------

// File: rtl/scr_pkg.sv
// Shared constants and types for the 802.11a x^7 + x^4 + 1 scrambler.
package scr_pkg;

  localparam int LFSR_W     = 7;
  localparam int POLY_TAP_A = 7;
  localparam int POLY_TAP_B = 4;
  localparam int CNT_W      = 5;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 7'h7F;

  typedef enum logic [1:0] {
    MODE_SCR        = 2'd0,
    MODE_DESCR_REC  = 2'd1,
    MODE_DESCR_SEED = 2'd2,
    MODE_BYPASS     = 2'd3
  } scr_mode_e;

  // State bit k-1 holds polynomial stage s[k]; feedback is s[7] ^ s[4].
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[POLY_TAP_A-1] ^ s[POLY_TAP_B-1];
  endfunction

endpackage

// File: rtl/scr_lfsr_unroll.sv
// Combinational DATA_W-bit unrolling of the scrambler LFSR, including
// SERVICE-field seed recovery that may finish part way through a beat.
module scr_lfsr_unroll
  import scr_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int REC_BITS = 7
) (
  input  logic [LFSR_W-1:0] state_i,
  input  logic [DATA_W-1:0] data_i,
  input  scr_mode_e         mode_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [LFSR_W-1:0] s_v;
  logic [CNT_W-1:0]  c_v;
  logic [DATA_W-1:0] d_v;
  logic              fb_v;

  // Walk the beat bit 0 first, carrying LFSR state and recovery count.
  always_comb begin
    s_v  = state_i;
    c_v  = cnt_i;
    d_v  = '0;
    fb_v = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      fb_v = lfsr_fb(s_v);
      case (mode_i)
        MODE_BYPASS: begin
          d_v[j] = data_i[j];
        end
        MODE_DESCR_REC: begin
          if (c_v < CNT_W'(REC_BITS)) begin
            d_v[j] = 1'b0;
            s_v    = {s_v[LFSR_W-2:0], data_i[j]};
            c_v    = c_v + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            d_v[j] = data_i[j] ^ fb_v;
            s_v    = {s_v[LFSR_W-2:0], fb_v};
          end
        end
        default: begin
          d_v[j] = data_i[j] ^ fb_v;
          s_v    = {s_v[LFSR_W-2:0], fb_v};
        end
      endcase
    end
    state_o = s_v;
    data_o  = d_v;
    cnt_o   = c_v;
  end

endmodule

// File: rtl/scrambler_par.sv
// Multi-bit-per-cycle 802.11a scrambler/descrambler with a single registered
// output stage on a valid/ready stream.
module scrambler_par
  import scr_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = scr_pkg::SEED_DEFAULT,
  parameter int                REC_BITS     = 7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [LFSR_W-1:0] lfsr_state
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_eff_s, lfsr_nxt_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff_s, cnt_nxt_s;
  scr_mode_e         mode_q, mode_d, mode_eff_s;
  logic [DATA_W-1:0] out_data_q, out_data_d, proc_data_s;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              accept_s;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // A start pulse takes effect before any beat accepted in the same cycle.
  always_comb begin
    if (start) begin
      mode_eff_s = scr_mode_e'(mode);
      cnt_eff_s  = '0;
      if ((mode == MODE_SCR) || (mode == MODE_DESCR_SEED)) begin
        lfsr_eff_s = seed;
      end else begin
        lfsr_eff_s = SEED_DEFAULT;
      end
    end else begin
      mode_eff_s = mode_q;
      cnt_eff_s  = cnt_q;
      lfsr_eff_s = lfsr_q;
    end
  end

  scr_lfsr_unroll #(
    .DATA_W   (DATA_W),
    .REC_BITS (REC_BITS)
  ) u_unroll (
    .state_i (lfsr_eff_s),
    .data_i  (in_data),
    .mode_i  (mode_eff_s),
    .cnt_i   (cnt_eff_s),
    .state_o (lfsr_nxt_s),
    .data_o  (proc_data_s),
    .cnt_o   (cnt_nxt_s)
  );

  // Next-state selection: the LFSR only advances on an accepted beat.
  always_comb begin
    mode_d = mode_eff_s;
    if (accept_s) begin
      lfsr_d      = lfsr_nxt_s;
      cnt_d       = cnt_nxt_s;
      out_data_d  = proc_data_s;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
    end else begin
      lfsr_d      = lfsr_eff_s;
      cnt_d       = cnt_eff_s;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !out_ready;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_q      <= SEED_DEFAULT;
      cnt_q       <= '0;
      mode_q      <= MODE_SCR;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_scrambler_par.sv
// Directed-plus-random bench for scrambler_par against a keystream-recurrence model.
module tb_scrambler_par;

  logic       Clk = 1'b0;
  logic       Reset, start, in_valid, in_last, out_ready;
  logic [1:0] mode;
  logic [6:0] seed;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;
  logic [6:0] lfsr_state;

  int errors = 0;
  int checks = 0;

  // Model: history of keystream/recovered bits in time order, x[n] = x[n-7] ^ x[n-4].
  bit         hist[$];
  int         m_rec;
  logic [1:0] m_mode;

  always #5 Clk = ~Clk;

  scrambler_par #(.DATA_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .mode(mode), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .lfsr_state(lfsr_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] m_state();
    logic [6:0] r;
    for (int k = 1; k <= 7; k++) r[k-1] = hist[hist.size()-k];
    return r;
  endfunction

  task automatic model_start(input logic [1:0] m, input logic [6:0] sd);
    logic [6:0] s0;
    s0 = (m == 2'd0 || m == 2'd2) ? sd : 7'h7F;
    hist.delete();
    for (int k = 6; k >= 0; k--) hist.push_back(s0[k]);
    m_mode = m;
    m_rec  = 0;
  endtask

  task automatic model_beat(input logic [7:0] d, output logic [7:0] e);
    bit ks;
    e = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (m_mode == 2'd3) begin
        e[j] = d[j];
      end else if (m_mode == 2'd1 && m_rec < 7) begin
        e[j] = 1'b0;
        hist.push_back(d[j]);
        m_rec++;
      end else begin
        ks = hist[hist.size()-7] ^ hist[hist.size()-4];
        e[j] = d[j] ^ ks;
        hist.push_back(ks);
      end
      while (hist.size() > 7) void'(hist.pop_front());
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [6:0] sd);
    start = 1'b1; mode = m; seed = sd; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    model_start(m, sd);
    chk("start_lfsr", lfsr_state, m_state());
  endtask

  task automatic send(input logic [7:0] d, input logic l, input string tag, output logic [7:0] e);
    in_valid = 1'b1; in_data = d; in_last = l; out_ready = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(d, e);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, e);
    chk({tag, "_last"}, out_last, l);
    chk({tag, "_lfsr"}, lfsr_state, m_state());
  endtask

  initial begin : main
    logic [7:0] e, held, cur_d, exp_od;
    logic [7:0] pt[16];
    logic [7:0] ct[16];
    logic       exp_ov, exp_ol, exp_rdy, r, cur_l;
    int         beat_idx;

    Reset = 1'b1; start = 1'b0; mode = 2'd0; seed = 7'h00;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_lfsr", lfsr_state, 7'h7F);
    chk("rst_ready", in_ready, 1'b1);
    Reset = 1'b0;

    // Known keystream from the all-ones seed, then a full 127-beat period.
    do_start(2'd0, 7'h7F);
    send(8'h00, 1'b0, "ks0", e);
    chk("ks0_const", out_data, 8'h70);
    send(8'h00, 1'b0, "ks1", e);
    chk("ks1_const", out_data, 8'h4F);
    for (int i = 2; i < 127; i++) begin
      send(8'h00, 1'b0, "period", e);
      chk("nonzero", (lfsr_state != 7'h00), 1'b1);
    end
    chk("period_wrap", lfsr_state, 7'h7F);

    // Scramble, then descramble with recovery and with the known seed.
    pt[0] = 8'($urandom) & 8'h80;
    for (int i = 1; i < 16; i++) pt[i] = 8'($urandom);
    do_start(2'd0, 7'h5D);
    for (int i = 0; i < 16; i++) begin
      send(pt[i], (i == 15), "scr", e);
      ct[i] = e;
    end
    do_start(2'd1, 7'h00);
    for (int i = 0; i < 16; i++) begin
      send(ct[i], (i == 15), "rec", e);
      chk("rec_plain", out_data, pt[i]);
    end
    do_start(2'd2, 7'h5D);
    for (int i = 0; i < 16; i++) begin
      send(ct[i], (i == 15), "dseed", e);
      chk("dseed_plain", out_data, pt[i]);
    end

    // Bypass leaves data and LFSR untouched; zero seed gives a zero keystream.
    do_start(2'd3, 7'h11);
    for (int i = 0; i < 4; i++) begin
      cur_d = 8'($urandom);
      send(cur_d, 1'b0, "byp", e);
      chk("byp_data", out_data, cur_d);
      chk("byp_lfsr", lfsr_state, 7'h7F);
    end
    do_start(2'd0, 7'h00);
    for (int i = 0; i < 4; i++) begin
      cur_d = 8'($urandom);
      send(cur_d, 1'b0, "zseed", e);
      chk("zseed_data", out_data, cur_d);
    end

    // Random backpressure with continuous in_valid.
    do_start(2'd0, 7'($urandom_range(1, 127)));
    exp_ov = 1'b0; exp_od = 8'h00; exp_ol = 1'b0;
    cur_d = 8'($urandom); beat_idx = 0;
    for (int c = 0; c < 200; c++) begin
      r = 1'($urandom_range(0, 1));
      cur_l = ((beat_idx % 5) == 4);
      out_ready = r; in_valid = 1'b1; in_data = cur_d; in_last = cur_l;
      exp_rdy = !exp_ov || r;
      #1;
      chk("bp_ready", in_ready, exp_rdy);
      @(posedge Clk); #1;
      if (exp_rdy) begin
        model_beat(cur_d, exp_od);
        exp_ol = cur_l;
        exp_ov = 1'b1;
        cur_d = 8'($urandom);
        beat_idx++;
      end
      chk("bp_valid", out_valid, exp_ov);
      chk("bp_data", out_data, exp_od);
      chk("bp_last", out_last, exp_ol);
      chk("bp_lfsr", lfsr_state, m_state());
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge Clk); #1;
    chk("bp_drain", out_valid, 1'b0);

    // start together with an accepted beat: the beat uses the new seed.
    cur_d = 8'($urandom);
    start = 1'b1; mode = 2'd0; seed = 7'h2A;
    in_valid = 1'b1; in_data = cur_d; in_last = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_start(2'd0, 7'h2A);
    model_beat(cur_d, held);
    chk("sa_data", out_data, held);
    chk("sa_lfsr", lfsr_state, m_state());

    // start during a stall: held beat unchanged, new seed loaded at once.
    out_ready = 1'b0;
    @(posedge Clk); #1;
    start = 1'b1; mode = 2'd2; seed = 7'h33; in_valid = 1'b1; in_data = 8'hA5;
    @(posedge Clk); #1;
    start = 1'b0;
    model_start(2'd2, 7'h33);
    chk("ss_data", out_data, held);
    chk("ss_valid", out_valid, 1'b1);
    chk("ss_last", out_last, 1'b1);
    chk("ss_lfsr", lfsr_state, 7'h33);
    chk("ss_ready", in_ready, 1'b0);
    out_ready = 1'b1; cur_d = 8'($urandom); in_data = cur_d;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    model_beat(cur_d, e);
    chk("ss_next_data", out_data, e);
    chk("ss_next_lfsr", lfsr_state, m_state());

    // Reset mid-frame overrides start and in_valid.
    out_ready = 1'b0; Reset = 1'b1; start = 1'b1; mode = 2'd0; seed = 7'h01;
    in_valid = 1'b1; in_data = 8'hFF;
    @(posedge Clk); #1;
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_lfsr", lfsr_state, 7'h7F);
    chk("mr_ready", in_ready, 1'b1);
    chk("mr_data", out_data, 8'h00);
    Reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge Clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
